mips_boot_ctrl: RTL and testbench
=================================

Name: mips_boot_ctrl

Overview:
Synthesizable boot and run controller for the single-cycle MIPS32 core. It streams a program image into instruction memory over a valid/ready handshake and holds the core's PC clear while loading. It then releases the core and monitors the fetched opcode for HALT, with a watchdog and a cycle counter. It replaces file-based program preload and fixed-delay result checks with a reusable, parametrised block.

Parameters:
ADDR_W, 10, instruction memory address width (DEPTH = 2**ADDR_W words)
DATA_W, 32, instruction word width
CLR_CYCLES, 2, cycles cpu_clr_PC stays asserted after load completes (1..15)
WDOG_CYCLES, 4096, RUN cycles allowed before timeout (>=2)
CNT_W, 16, cycle_count width (must hold WDOG_CYCLES)

Ports:
clk  in  1  system clock, rising edge
clr_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins LOAD (honoured only in IDLE, HALTED, TIMEOUT, FAULT)
in_valid  in  1  program word valid
in_ready  out  1  controller accepts a word
in_data  in  DATA_W  program word
in_last  in  1  marks the final program word
imem_we  out  1  instruction memory write enable
imem_addr  out  ADDR_W  instruction memory write address
imem_wdata  out  DATA_W  instruction memory write data
cpu_clr_PC  out  1  active-high PC clear to the core
cpu_opcode  in  6  opcode of the instruction currently fetched by the core
busy  out  1  state is LOAD, CLEAR or RUN
done  out  1  HALT opcode observed
timeout  out  1  watchdog expired
err_overflow  out  1  image exceeded DEPTH
word_count  out  ADDR_W+1  words accepted in the last load
cycle_count  out  CNT_W  RUN cycles elapsed

Behaviour:
- Reset (async, clr_n=0) puts the block in IDLE.
  - cpu_clr_PC=1.
  - All other outputs and counters are 0.
  - Reset mid-operation aborts immediately. A partially loaded image is left in memory and is not erased.
- States are IDLE, LOAD, CLEAR, RUN, HALTED, TIMEOUT, FAULT.
  - cpu_clr_PC=0 only in RUN.
  - in_ready=1 only in LOAD.
- IDLE/HALTED/TIMEOUT/FAULT → LOAD on start.
  - The transition clears done, timeout, err_overflow, word_count, cycle_count and the write pointer.
- LOAD: a handshake is in_valid & in_ready.
  - One cycle after each handshake: imem_we=1, imem_addr=pointer, imem_wdata=in_data.
  - The pointer and word_count increment on each handshake. in_ready may be seen high without a transfer; no write results.
  - Handshake with in_last=1 → CLEAR. This takes priority over overflow.
  - Handshake at pointer DEPTH-1 with in_last=0: the word is written, err_overflow=1, → FAULT.
  - imem_we is never asserted in any state except the cycle following a handshake.
- CLEAR: holds cpu_clr_PC=1 for exactly CLR_CYCLES cycles, then → RUN. The final word's write occurs in the first CLEAR cycle.
- RUN: cycle_count increments every cycle, saturating at all-ones.
  - cpu_opcode==6'h3F → HALTED, done=1. The cycle_count value stays as it was on that cycle.
  - Otherwise, when cycle_count==WDOG_CYCLES-1 → TIMEOUT, timeout=1, cycle_count=WDOG_CYCLES.
  - HALT and watchdog expiry in the same cycle → HALTED; timeout stays 0.
- HALTED/TIMEOUT/FAULT are sticky until start. cpu_clr_PC=1 in these states, freezing the core; data memory is untouched.
- done, timeout and err_overflow are registered and mutually exclusive.
- start is ignored in LOAD, CLEAR and RUN. in_valid is ignored outside LOAD.

Optional Feature:
MIPS_BOOT_CHECKSUM_EN:
- Defined: adds output load_checksum [DATA_W-1:0], the sum mod 2**DATA_W of all words accepted in the current load. It is cleared on start and on reset, and is valid from CLEAR onward.
- Undefined: no port and no adder; all other behaviour is identical.

Decomposition:
- Package mips_boot_pkg holds:
  - state enum boot_state_t (7 states);
  - localparam HALT_OPCODE = 6'h3F;
  - DEFAULT_WDOG.
- One sub-module, boot_run_counter: saturating cycle counter with an expiry compare against WDOG_CYCLES. The FSM, load path and checksum stay in the top module.

Test Plan:
- Factorial load: start, then 7 words 200100c8, 28020001, 14411000, 2c210001, 3420fffd, 240200c6, fc000000, in_last on the 7th → imem writes addr 0..6 with matching data, word_count=7, cpu_clr_PC high for 2 cycles after the last write, then low.
- Halt detect: in RUN, drive cpu_opcode 6'h08 for 20 cycles then 6'h3F → done=1 next edge, cycle_count=20, cpu_clr_PC=1, busy=0.
- Watchdog: WDOG_CYCLES=16, cpu_opcode never 3F → timeout=1 with cycle_count=16 exactly 16 RUN cycles after release. Second case: opcode 3F on cycle 15 → done=1, timeout=0.
- Overflow/backpressure: ADDR_W=3, in_valid toggled randomly, 9 words with no in_last → 8 writes (addr 0..7), err_overflow=1, FAULT, in_ready=0. A start then reloads cleanly from addr 0.
- Reset mid-RUN: clr_n low for 3 ns between edges → outputs immediately at reset values, cpu_clr_PC=1; after release, start restarts at addr 0.
- With MIPS_BOOT_CHECKSUM_EN: factorial image → load_checksum = 32-bit wrapped sum of the 7 words. A reload with words 1,2,3 → 6.

Source files
------------

// File: rtl/mips_boot_pkg.sv
// Shared types and constants for the MIPS32 boot/run controller.
package mips_boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CLEAR,
        ST_RUN,
        ST_HALTED,
        ST_TIMEOUT,
        ST_FAULT
    } boot_state_t;

    localparam logic [5:0] HALT_OPCODE  = 6'h3F;
    localparam int         DEFAULT_WDOG = 4096;

endpackage

// File: rtl/mips_boot_if.sv
// Program-stream handshake plus instruction-memory write port of the boot controller.
interface mips_boot_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;

    // master: program source / memory side; slave: the boot controller
    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );
    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/boot_run_counter.sv
// Saturating RUN-cycle counter with a watchdog expiry compare.
module boot_run_counter #(
    parameter int CNT_W       = 16,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             expired
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WDOG_CYCLES - 1);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/mips_boot_ctrl.sv
// Boot and run controller: streams an image into imem, releases the core, watches for HALT.
// Optional `MIPS_BOOT_CHECKSUM_EN adds a load_checksum output (wrapped sum of accepted words).
module mips_boot_ctrl
    import mips_boot_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int CLR_CYCLES  = 2,
    parameter int WDOG_CYCLES = DEFAULT_WDOG,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              start,
    mips_boot_if.slave        bus,
    output logic              cpu_clr_PC,
    input  logic [5:0]        cpu_opcode,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              err_overflow,
    output logic [ADDR_W:0]   word_count,
    output logic [CNT_W-1:0]  cycle_count
`ifdef MIPS_BOOT_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] load_checksum
`endif
);
    localparam logic [3:0] CLR_LAST = 4'(CLR_CYCLES - 1);

    boot_state_t       state_q, state_d;
    logic [ADDR_W:0]   wcnt_q;
    logic [3:0]        clr_cnt_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              done_q, timeout_q, ovf_q;
    logic              hs, load_go, halt_hit, wdog_hit, ovf_hit, run_inc, wdog_expired;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        state_d  = state_q;
        hs       = 1'b0;
        load_go  = 1'b0;
        halt_hit = 1'b0;
        wdog_hit = 1'b0;
        ovf_hit  = 1'b0;
        run_inc  = 1'b0;
        case (state_q)
            ST_IDLE, ST_HALTED, ST_TIMEOUT, ST_FAULT: begin
                if (start) begin
                    load_go = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                hs = bus.in_valid;
                if (hs) begin
                    // in_last wins over overflow when the final word lands on the last address
                    if (bus.in_last) begin
                        state_d = ST_CLEAR;
                    end else if (wcnt_q[ADDR_W-1:0] == {ADDR_W{1'b1}}) begin
                        ovf_hit = 1'b1;
                        state_d = ST_FAULT;
                    end
                end
            end
            ST_CLEAR: begin
                if (clr_cnt_q == CLR_LAST) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (cpu_opcode == HALT_OPCODE) begin
                    halt_hit = 1'b1;
                    state_d  = ST_HALTED;
                end else begin
                    run_inc = 1'b1;
                    if (wdog_expired) begin
                        wdog_hit = 1'b1;
                        state_d  = ST_TIMEOUT;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            wcnt_q    <= '0;
            clr_cnt_q <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            we_q      <= hs;
            clr_cnt_q <= (state_q == ST_CLEAR) ? clr_cnt_q + 4'd1 : 4'd0;
            if (hs) begin
                addr_q  <= wcnt_q[ADDR_W-1:0];
                wdata_q <= bus.in_data;
                wcnt_q  <= wcnt_q + 1'b1;
            end
            if (load_go) begin
                wcnt_q    <= '0;
                done_q    <= 1'b0;
                timeout_q <= 1'b0;
                ovf_q     <= 1'b0;
            end else begin
                if (halt_hit) done_q    <= 1'b1;
                if (wdog_hit) timeout_q <= 1'b1;
                if (ovf_hit)  ovf_q     <= 1'b1;
            end
        end
    end

    boot_run_counter #(
        .CNT_W      (CNT_W),
        .WDOG_CYCLES(WDOG_CYCLES)
    ) u_run_counter (
        .clk    (clk),
        .clr_n  (clr_n),
        .clear  (load_go),
        .inc    (run_inc),
        .count  (cycle_count),
        .expired(wdog_expired)
    );

`ifdef MIPS_BOOT_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)       csum_q <= '0;
        else if (load_go) csum_q <= '0;
        else if (hs)      csum_q <= csum_q + bus.in_data;
    end

    assign load_checksum = csum_q;
`endif

    assign bus.in_ready   = (state_q == ST_LOAD);
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign cpu_clr_PC     = (state_q != ST_RUN);
    assign busy           = (state_q == ST_LOAD) || (state_q == ST_CLEAR) || (state_q == ST_RUN);
    assign done           = done_q;
    assign timeout        = timeout_q;
    assign err_overflow   = ovf_q;
    assign word_count     = wcnt_q;

endmodule

// File: tb/tb_mips_boot_ctrl.sv
// Self-checking bench: two controller instances (large/default and small ADDR_W=3, WDOG=16).
module tb_mips_boot_ctrl;

    localparam int CLR = 2;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic [5:0]  cpu_opcode = 6'h08;
    bit          sel = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Instance A: ADDR_W=10, WDOG=4096
    logic        start_a, clr_a, busy_a, done_a, to_a, err_a;
    logic [10:0] wc_a;
    logic [15:0] cc_a;
    // Instance B: ADDR_W=3, WDOG=16
    logic        start_b, clr_b, busy_b, done_b, to_b, err_b;
    logic [3:0]  wc_b;
    logic [7:0]  cc_b;
`ifdef MIPS_BOOT_CHECKSUM_EN
    logic [31:0] cs_a, cs_b;
`endif

    mips_boot_if #(.ADDR_W(10), .DATA_W(32)) bus_a ();
    mips_boot_if #(.ADDR_W(3),  .DATA_W(32)) bus_b ();

    assign start_a        = start & ~sel;
    assign start_b        = start & sel;
    assign bus_a.in_valid = in_valid;
    assign bus_a.in_data  = in_data;
    assign bus_a.in_last  = in_last;
    assign bus_b.in_valid = in_valid;
    assign bus_b.in_data  = in_data;
    assign bus_b.in_last  = in_last;

    mips_boot_ctrl #(.ADDR_W(10), .DATA_W(32), .CLR_CYCLES(CLR), .WDOG_CYCLES(4096), .CNT_W(16)) dut_a (
        .clk(clk), .clr_n(clr_n), .start(start_a), .bus(bus_a), .cpu_clr_PC(clr_a),
        .cpu_opcode(cpu_opcode), .busy(busy_a), .done(done_a), .timeout(to_a),
        .err_overflow(err_a), .word_count(wc_a), .cycle_count(cc_a)
`ifdef MIPS_BOOT_CHECKSUM_EN
        , .load_checksum(cs_a)
`endif
    );

    mips_boot_ctrl #(.ADDR_W(3), .DATA_W(32), .CLR_CYCLES(CLR), .WDOG_CYCLES(16), .CNT_W(8)) dut_b (
        .clk(clk), .clr_n(clr_n), .start(start_b), .bus(bus_b), .cpu_clr_PC(clr_b),
        .cpu_opcode(cpu_opcode), .busy(busy_b), .done(done_b), .timeout(to_b),
        .err_overflow(err_b), .word_count(wc_b), .cycle_count(cc_b)
`ifdef MIPS_BOOT_CHECKSUM_EN
        , .load_checksum(cs_b)
`endif
    );

    // Observation mux: everything below looks at the selected instance
    logic        obs_ready, obs_we, obs_clr, obs_busy, obs_done, obs_to, obs_err;
    logic [9:0]  obs_addr;
    logic [31:0] obs_wdata;
    logic [10:0] obs_wc;
    logic [15:0] obs_cc;
    assign obs_ready = sel ? bus_b.in_ready : bus_a.in_ready;
    assign obs_we    = sel ? bus_b.imem_we  : bus_a.imem_we;
    assign obs_addr  = sel ? 10'(bus_b.imem_addr) : bus_a.imem_addr;
    assign obs_wdata = sel ? bus_b.imem_wdata : bus_a.imem_wdata;
    assign obs_clr   = sel ? clr_b  : clr_a;
    assign obs_busy  = sel ? busy_b : busy_a;
    assign obs_done  = sel ? done_b : done_a;
    assign obs_to    = sel ? to_b   : to_a;
    assign obs_err   = sel ? err_b  : err_a;
    assign obs_wc    = sel ? 11'(wc_b) : wc_a;
    assign obs_cc    = sel ? 16'(cc_b) : cc_a;
`ifdef MIPS_BOOT_CHECKSUM_EN
    logic [31:0] obs_cs;
    assign obs_cs = sel ? cs_b : cs_a;
`endif

    // Memory-side model: every write the selected instance issues, in order
    logic [41:0] wr_q[$];
    always @(negedge clk) if (obs_we) wr_q.push_back({obs_addr, obs_wdata});

    logic [31:0] img[$];
    int          exp_writes;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_clr"},   obs_clr,   1);
        check({tag, "_ready"}, obs_ready, 0);
        check({tag, "_busy"},  obs_busy,  0);
        check({tag, "_flags"}, {obs_done, obs_to, obs_err}, 0);
        check({tag, "_wc"},    obs_wc,    0);
        check({tag, "_cc"},    obs_cc,    0);
        check({tag, "_we"},    obs_we,    0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Streams img; the model says which words must land where and what state follows.
    task automatic load_img(input bit with_last, input bit rand_valid);
        int          depth, n, exp_acc, acc, guard;
        logic [31:0] sum;
        depth   = sel ? 8 : 1024;
        n       = img.size();
        exp_acc = (!with_last && n > depth) ? depth : n;
        sum     = '0;
        for (int k = 0; k < exp_acc; k++) sum = sum + img[k];
        wr_q.delete();
        pulse_start();
        check("ld_ready", obs_ready, 1);
        check("ld_cleared", {obs_done, obs_to, obs_err, obs_wc, obs_cc}, 0);
        acc = 0;
        for (int k = 0; k < n; k++) begin
            if (rand_valid) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    @(negedge clk);
                end
            end
            in_valid = 1'b1;
            in_data  = img[k];
            in_last  = with_last && (k == n - 1);
            guard    = 0;
            while (!obs_ready && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            if (!obs_ready) break;
            @(negedge clk);
            acc++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (with_last) begin
            check("clr_last_we",   {obs_we, obs_addr}, {1'b1, 10'(n - 1)});
            check("clr_last_data", obs_wdata, img[n-1]);
            for (int c = 0; c < CLR; c++) begin
                check("clear_clr_pc", {obs_clr, obs_busy}, 2'b11);
                @(negedge clk);
            end
            check("release_clr_pc", {obs_clr, obs_busy}, 2'b01);
        end else begin
            check("ovf_flags", {obs_done, obs_to, obs_err}, 3'b001);
            check("ovf_state", {obs_ready, obs_busy, obs_clr}, 3'b001);
        end
        check("accepted", acc, exp_acc);
        check("word_count", obs_wc, exp_acc);
        check("wr_count", wr_q.size(), exp_acc);
        for (int k = 0; k < wr_q.size() && k < exp_acc; k++)
            check("wr_entry", wr_q[k], {10'(k), img[k]});
        exp_writes = exp_acc;
`ifdef MIPS_BOOT_CHECKSUM_EN
        check("checksum", obs_cs, sum);
`endif
    endtask

    // Called at the first RUN cycle; opcode for RUN cycle i is driven before its edge.
    task automatic run_phase(input int halt_at, input bit rand_ops, input int start_at);
        int  wdog, cyc, exp_cycles, exp_cc;
        bit  exp_halt;
        wdog       = sel ? 16 : 4096;
        exp_halt   = (halt_at >= 0) && (halt_at < wdog);
        exp_cycles = exp_halt ? halt_at + 1 : wdog;
        exp_cc     = exp_halt ? halt_at : wdog;
        cyc        = 0;
        while (cyc < wdog + 8) begin
            if (cyc == halt_at)  cpu_opcode = 6'h3F;
            else if (rand_ops)   cpu_opcode = 6'($urandom_range(0, 62));
            else                 cpu_opcode = 6'h08;
            start = (cyc == start_at);
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (!obs_busy) break;
            if (cyc == 20 && halt_at == 20) check("cc_before_halt", obs_cc, 20);
        end
        cpu_opcode = 6'h08;
        check("run_cycles", cyc, exp_cycles);
        check("run_flags", {obs_done, obs_to, obs_err}, exp_halt ? 3'b100 : 3'b010);
        check("run_cc", obs_cc, exp_cc);
        check("run_end_state", {obs_clr, obs_busy, obs_ready}, 3'b100);
        check("run_no_writes", wr_q.size(), exp_writes);
    endtask

    initial begin
        #3;
        check_reset_values("rst_a");
        sel = 1'b1;
        #1;
        check_reset_values("rst_b");
        sel = 1'b0;
        #8 clr_n = 1'b1;
        @(negedge clk);

        // Factorial image on instance A, then halt after 20 RUN cycles of opcode 08
        img = '{32'h200100c8, 32'h28020001, 32'h14411000, 32'h2c210001,
                32'h3420fffd, 32'h240200c6, 32'hfc000000};
        load_img(1'b1, 1'b0);
        run_phase(20, 1'b0, 5);

        // Instance B: watchdog expiry, then halt coinciding with the last watchdog cycle
        sel = 1'b1;
        img.delete();
        repeat (5) img.push_back($urandom);
        load_img(1'b1, 1'b1);
        run_phase(-1, 1'b1, -1);
        load_img(1'b1, 1'b1);
        run_phase(15, 1'b1, -1);

        // Overflow with backpressure, then clean reload of 1,2,3
        img.delete();
        repeat (9) img.push_back($urandom);
        load_img(1'b0, 1'b1);
        img = '{32'd1, 32'd2, 32'd3};
        load_img(1'b1, 1'b0);
        run_phase(int'($urandom_range(0, 10)), 1'b1, 2);

        // Final word on the last address: in_last wins, no overflow
        img.delete();
        repeat (8) img.push_back($urandom);
        load_img(1'b1, 1'b1);
        run_phase(int'($urandom_range(0, 15)), 1'b1, -1);

        // Random loads and run lengths (some past the watchdog)
        for (int t = 0; t < 4; t++) begin
            img.delete();
            repeat ($urandom_range(1, 8)) img.push_back($urandom);
            load_img(1'b1, 1'b1);
            run_phase(int'($urandom_range(0, 22)), 1'b1, int'($urandom_range(0, 6)));
        end

        // Reset in the middle of RUN on instance A, between clock edges
        sel = 1'b0;
        img.delete();
        repeat (3) img.push_back($urandom);
        load_img(1'b1, 1'b0);
        repeat (4) @(negedge clk);
        #1 clr_n = 1'b0;
        #1 check_reset_values("midrun_rst");
        #2 clr_n = 1'b1;
        @(negedge clk);
        check_reset_values("post_rst");
        load_img(1'b1, 1'b1);
        run_phase(3, 1'b1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
